// File: rtl/nmr_seq_ctrl.sv
// CPMG sequence controller: issues one-cycle start requests to the timed states,
// tracks their clk_en feedback, counts echoes and raises early-termination pulses.
module nmr_seq_ctrl #(
    parameter int ECHO_W      = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              seq_go,
    input  logic              seq_abort,
    input  logic [ECHO_W-1:0] echo_num,
    input  logic              noise_en,
    input  logic              clk_en_st1ms,
    input  logic              clk_en_pluse,
    input  logic              clk_en_scale,
    input  logic              clk_en_scan,
    input  logic              clk_en_noise,
    output logic [4:0]        start,
    output logic [3:0]        state_over_in,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic              acq_trig,
    output logic [ECHO_W-1:0] echo_cnt
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        PH_ST1MS = 3'd0,
        PH_P90   = 3'd1,
        PH_TAU   = 3'd2,
        PH_P180  = 3'd3,
        PH_SCAN  = 3'd4,
        PH_NOISE = 3'd5
    } phase_t;

    // P90 and P180 share the pluse timer channel.
    function automatic logic [4:0] start_vec(input phase_t p);
        case (p)
            PH_ST1MS: start_vec = 5'b00001;
            PH_P90:   start_vec = 5'b00010;
            PH_TAU:   start_vec = 5'b00100;
            PH_P180:  start_vec = 5'b00010;
            PH_SCAN:  start_vec = 5'b01000;
            PH_NOISE: start_vec = 5'b10000;
            default:  start_vec = 5'b00000;
        endcase
    endfunction

    function automatic logic [3:0] over_vec(input phase_t p);
        logic [4:0] s;
        s = start_vec(p);
        over_vec = s[3:0];
    endfunction

    state_t            state_q;
    phase_t            phase_q;
    logic [4:0]        en_q;
    logic              scan_prev_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [ECHO_W-1:0] rem_q;
    logic              noise_q;
    logic              abort_pend_q;
    logic [4:0]        start_q;
    logic [3:0]        over_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              acq_q;
    logic [ECHO_W-1:0] echo_cnt_q;

    logic              en_sel_d;
    logic [ECHO_W-1:0] rem_left_d;
    phase_t            nxt_phase_d;
    logic              fin_d;

    // Feedback of the current phase's timer channel.
    always_comb begin
        en_sel_d = 1'b0;
        case (phase_q)
            PH_ST1MS: en_sel_d = en_q[0];
            PH_P90:   en_sel_d = en_q[1];
            PH_TAU:   en_sel_d = en_q[2];
            PH_P180:  en_sel_d = en_q[1];
            PH_SCAN:  en_sel_d = en_q[3];
            PH_NOISE: en_sel_d = en_q[4];
            default:  en_sel_d = 1'b0;
        endcase
    end

    // Phase that follows the current one once its clk_en has fallen.
    always_comb begin
        nxt_phase_d = PH_ST1MS;
        fin_d       = 1'b0;
        if (phase_q == PH_SCAN) begin
            rem_left_d = rem_q - ECHO_W'(1);
        end else begin
            rem_left_d = rem_q;
        end
        case (phase_q)
            PH_ST1MS: nxt_phase_d = PH_P90;
            PH_P90:   nxt_phase_d = PH_TAU;
            PH_P180:  nxt_phase_d = PH_SCAN;
            PH_TAU, PH_SCAN: begin
                if (rem_left_d != '0) begin
                    nxt_phase_d = PH_P180;
                end else if (noise_q) begin
                    nxt_phase_d = PH_NOISE;
                end else begin
                    fin_d = 1'b1;
                end
            end
            PH_NOISE: fin_d = 1'b1;
            default:  fin_d = 1'b1;
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_ST1MS;
            en_q         <= 5'b00000;
            scan_prev_q  <= 1'b0;
            tmo_q        <= '0;
            rem_q        <= '0;
            noise_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            start_q      <= 5'b00000;
            over_q       <= 4'b0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            acq_q        <= 1'b0;
            echo_cnt_q   <= '0;
        end else begin
            en_q        <= {clk_en_noise, clk_en_scan, clk_en_scale, clk_en_pluse, clk_en_st1ms};
            scan_prev_q <= en_q[3];
            acq_q       <= busy_q & en_q[3] & ~scan_prev_q;
            start_q     <= 5'b00000;
            over_q      <= 4'b0000;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seq_go) begin
                        rem_q        <= echo_num;
                        noise_q      <= noise_en;
                        echo_cnt_q   <= '0;
                        err_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                        phase_q      <= PH_ST1MS;
                        start_q      <= start_vec(PH_ST1MS);
                        state_q      <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // An abort seen here is acted on from WAIT_HI.
                    abort_pend_q <= seq_abort;
                    tmo_q        <= '0;
                    state_q      <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (seq_abort || abort_pend_q || (!en_sel_d && tmo_q == TMO_MAX)) begin
                        over_q       <= over_vec(phase_q);
                        err_q        <= 1'b1;
                        abort_pend_q <= 1'b0;
                        state_q      <= S_DRAIN;
                    end else if (en_sel_d) begin
                        state_q <= S_WAIT_LO;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (seq_abort) begin
                        over_q  <= over_vec(phase_q);
                        err_q   <= 1'b1;
                        state_q <= S_DRAIN;
                    end else if (!en_sel_d) begin
                        if (phase_q == PH_SCAN) begin
                            rem_q <= rem_left_d;
                            if (echo_cnt_q != '1) begin
                                echo_cnt_q <= echo_cnt_q + ECHO_W'(1);
                            end
                        end
                        if (fin_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            phase_q <= nxt_phase_d;
                            start_q <= start_vec(nxt_phase_d);
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_DRAIN: begin
                    if (en_q == 5'b00000) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start         = start_q;
    assign state_over_in = over_q;
    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign seq_err       = err_q;
    assign acq_trig      = acq_q;
    assign echo_cnt      = echo_cnt_q;

endmodule

// File: tb/tb_nmr_seq_ctrl.sv
// Directed bench for nmr_seq_ctrl with a behavioural timer model answering start pulses.
module tb_nmr_seq_ctrl;

    localparam int ECHO_W      = 16;
    localparam int ACK_TIMEOUT = 16;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic              seq_go;
    logic              seq_abort;
    logic [ECHO_W-1:0] echo_num;
    logic              noise_en;
    logic              clk_en_st1ms;
    logic              clk_en_pluse;
    logic              clk_en_scale;
    logic              clk_en_scan;
    logic              clk_en_noise;
    logic [4:0]        start;
    logic [3:0]        state_over_in;
    logic              seq_busy;
    logic              seq_done;
    logic              seq_err;
    logic              acq_trig;
    logic [ECHO_W-1:0] echo_cnt;

    nmr_seq_ctrl #(.ECHO_W(ECHO_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .seq_go        (seq_go),
        .seq_abort     (seq_abort),
        .echo_num      (echo_num),
        .noise_en      (noise_en),
        .clk_en_st1ms  (clk_en_st1ms),
        .clk_en_pluse  (clk_en_pluse),
        .clk_en_scale  (clk_en_scale),
        .clk_en_scan   (clk_en_scan),
        .clk_en_noise  (clk_en_noise),
        .start         (start),
        .state_over_in (state_over_in),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .seq_err       (seq_err),
        .acq_trig      (acq_trig),
        .echo_cnt      (echo_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [4:0] starts[$];
    int         start_cyc[$];
    int         n_acq, n_done, n_soi, soi_cyc, done_cyc;
    logic [3:0] last_soi;
    logic       busy_at_done;

    int         hold_len[5];
    logic [4:0] mute;
    logic       drop_scan;
    int         en_cnt[5];

    logic [4:0] exp_nom[8];
    logic [4:0] exp_short[8];
    logic [4:0] exp_abort[8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Timer model: each start raises its clk_en for hold_len cycles.
    initial begin
        for (int k = 0; k < 5; k++) en_cnt[k] = 0;
        {clk_en_noise, clk_en_scan, clk_en_scale, clk_en_pluse, clk_en_st1ms} = 5'b00000;
        forever begin
            @(negedge clk_sys);
            for (int k = 0; k < 5; k++) begin
                if (rst) begin
                    en_cnt[k] = 0;
                end else begin
                    if (en_cnt[k] > 0) en_cnt[k]--;
                    if (k == 3 && drop_scan) en_cnt[k] = 0;
                    if (start[k] && !mute[k]) en_cnt[k] = hold_len[k];
                end
            end
            clk_en_st1ms = (en_cnt[0] != 0);
            clk_en_pluse = (en_cnt[1] != 0);
            clk_en_scale = (en_cnt[2] != 0);
            clk_en_scan  = (en_cnt[3] != 0);
            clk_en_noise = (en_cnt[4] != 0);
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
        cyc++;
        if (start != 5'd0) begin
            starts.push_back(start);
            start_cyc.push_back(cyc);
        end
        if (acq_trig) n_acq++;
        if (seq_done) begin
            n_done++;
            done_cyc     = cyc;
            busy_at_done = seq_busy;
        end
        if (state_over_in != 4'd0) begin
            n_soi++;
            soi_cyc  = cyc;
            last_soi = state_over_in;
        end
    endtask

    task automatic clear_log();
        starts.delete();
        start_cyc.delete();
        n_acq = 0; n_done = 0; n_soi = 0; soi_cyc = 0; done_cyc = 0;
        last_soi = 4'd0; busy_at_done = 1'b1;
    endtask

    task automatic pulse_go(input logic [ECHO_W-1:0] en, input logic nz);
        echo_num = en;
        noise_en = nz;
        seq_go   = 1'b1;
        tick();
        seq_go   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            tick();
            i++;
        end
        check_val({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    endtask

    task automatic wait_acq(input string tag, input int n, input int budget);
        int i = 0;
        while (n_acq < n && i < budget) begin
            tick();
            i++;
        end
        check_val({tag, "_acq_seen"}, n_acq, n);
    endtask

    task automatic check_starts(input string tag, input logic [4:0] exp[8], input int n);
        check_val({tag, "_nstarts"}, starts.size(), n);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_start%0d", tag, i),
                      (i < starts.size()) ? 32'(starts[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        end
    endtask

    initial begin
        int c0;
        exp_nom   = '{5'h01, 5'h02, 5'h04, 5'h02, 5'h08, 5'h02, 5'h08, 5'h10};
        exp_short = '{5'h01, 5'h02, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        exp_abort = '{5'h01, 5'h02, 5'h04, 5'h02, 5'h08, 5'h02, 5'h08, 5'h00};
        for (int k = 0; k < 5; k++) hold_len[k] = 5;
        mute      = 5'b00000;
        drop_scan = 1'b0;
        rst       = 1'b1;
        seq_go    = 1'b0;
        seq_abort = 1'b0;
        echo_num  = '0;
        noise_en  = 1'b0;
        clear_log();

        // Reset state
        repeat (3) tick();
        check_val("rst_start", start, 5'd0);
        check_val("rst_soi", state_over_in, 4'd0);
        check_val("rst_busy", seq_busy, 1'b0);
        check_val("rst_done", seq_done, 1'b0);
        check_val("rst_err", seq_err, 1'b0);
        check_val("rst_echo", echo_cnt, 16'd0);
        rst = 1'b0;
        tick();

        // Nominal: echo_num=2, noise_en=1
        clear_log();
        pulse_go(16'd2, 1'b1);
        check_val("nom_busy", seq_busy, 1'b1);
        wait_done("nom", 200);
        repeat (3) tick();
        check_starts("nom", exp_nom, 8);
        check_val("nom_acq", n_acq, 2);
        check_val("nom_echo", echo_cnt, 16'd2);
        check_val("nom_ndone", n_done, 1);
        check_val("nom_busy_at_done", busy_at_done, 1'b0);
        check_val("nom_err", seq_err, 1'b0);
        check_val("nom_soi", n_soi, 0);

        // echo_num=0, noise_en=0
        clear_log();
        pulse_go(16'd0, 1'b0);
        wait_done("short", 100);
        repeat (3) tick();
        check_starts("short", exp_short, 3);
        check_val("short_echo", echo_cnt, 16'd0);
        check_val("short_ndone", n_done, 1);
        check_val("short_acq", n_acq, 0);

        // Timeout on scale
        mute = 5'b00100;
        clear_log();
        pulse_go(16'd1, 1'b0);
        wait_done("tmo", 200);
        repeat (2) tick();
        check_starts("tmo", exp_short, 3);
        check_val("tmo_nsoi", n_soi, 1);
        check_val("tmo_soi_val", last_soi, 4'b0100);
        check_val("tmo_soi_lat", (start_cyc.size() > 2) ? soi_cyc - start_cyc[2] : -1, 17);
        check_val("tmo_done_lat", done_cyc - soi_cyc, 1);
        check_val("tmo_err", seq_err, 1'b1);
        check_val("tmo_ndone", n_done, 1);
        mute = 5'b00000;

        // Abort during the second SCAN
        clear_log();
        pulse_go(16'd2, 1'b1);
        check_val("abort_err_clr", seq_err, 1'b0);
        wait_acq("abort1", 1, 100);
        hold_len[3] = 100;
        wait_acq("abort2", 2, 100);
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        check_val("abort_nsoi", n_soi, 1);
        check_val("abort_soi_val", last_soi, 4'b1000);
        check_val("abort_echo_mid", echo_cnt, 16'd1);
        repeat (2) tick();
        drop_scan = 1'b1;
        c0 = cyc;
        tick();
        drop_scan = 1'b0;
        hold_len[3] = 5;
        wait_done("abort", 20);
        repeat (2) tick();
        check_val("abort_done_lat", done_cyc - (c0 + 1), 2);
        check_val("abort_nsoi_end", n_soi, 1);
        check_val("abort_err", seq_err, 1'b1);
        check_val("abort_echo", echo_cnt, 16'd1);
        check_starts("abort", exp_abort, 7);

        // seq_go while busy, seq_abort while idle
        clear_log();
        pulse_go(16'd0, 1'b0);
        tick();
        echo_num = 16'd3;
        seq_go   = 1'b1;
        tick();
        seq_go   = 1'b0;
        wait_done("rego", 100);
        repeat (2) tick();
        check_starts("rego", exp_short, 3);
        check_val("rego_ndone", n_done, 1);
        check_val("rego_err", seq_err, 1'b0);
        clear_log();
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        repeat (4) tick();
        check_val("idle_abort_nstarts", starts.size(), 0);
        check_val("idle_abort_nsoi", n_soi, 0);
        check_val("idle_abort_ndone", n_done, 0);
        check_val("idle_abort_busy", seq_busy, 1'b0);
        check_val("idle_abort_err", seq_err, 1'b0);

        // Reset in the middle of P180
        clear_log();
        pulse_go(16'd1, 1'b0);
        for (int i = 0; i < 100 && starts.size() < 4; i++) tick();
        tick();
        tick();
        check_val("mid_busy_pre", seq_busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_start", start, 5'd0);
        check_val("mid_rst_soi", state_over_in, 4'd0);
        check_val("mid_rst_busy", seq_busy, 1'b0);
        check_val("mid_rst_done", seq_done, 1'b0);
        check_val("mid_rst_acq", acq_trig, 1'b0);
        check_val("mid_rst_echo", echo_cnt, 16'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_log();
        pulse_go(16'd0, 1'b0);
        wait_done("post_rst", 100);
        repeat (2) tick();
        check_starts("post_rst", exp_short, 3);
        check_val("post_rst_err", seq_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
